// File: rtl/boss_pkg.sv
// Boss FSM states, sprite size and the playfield bounds derived from it.
package boss_pkg;
  typedef enum logic [2:0] {IDLE, PATROL, CHARGE, RETURN, DEAD} boss_state_t;

  localparam int BOSS_LNG = 106;
  localparam int BOSS_HGT = 95;
  localparam int HP_MAX   = 100;

  localparam int X_MIN = BOSS_LNG;
  localparam int X_MAX = vga_pkg::HOR_PIXELS - BOSS_LNG;
  localparam int Y_LOW = vga_pkg::VER_PIXELS - BOSS_HGT;
endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the video timing generator and sprite logic.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
endpackage

// File: rtl/boss_hp_ctl.sv
// Boss hit points with saturating damage and a per-frame invulnerability window.
module boss_hp_ctl
  import boss_pkg::*;
#(
  parameter int INVULN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       live,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic [6:0] hit_dmg,
  output logic [6:0] hp,
  output logic       flash,
  output logic       hp_zero
);
  localparam int IW = $clog2(INVULN_FRAMES + 2);

  logic [IW-1:0] cnt, cnt_nxt;
  logic          accept;

  always_comb begin
    accept  = live && hit && (cnt == '0);
    hp_zero = accept && (hp <= hit_dmg);
    cnt_nxt = cnt;
    // A fresh hit reloads the window and wins over the frame decrement.
    if (accept)
      cnt_nxt = IW'(INVULN_FRAMES);
    else if (live && frame_tick && cnt != '0)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp    <= 7'(HP_MAX);
      cnt   <= '0;
      flash <= 1'b0;
    end else if (clr) begin
      hp    <= 7'(HP_MAX);
      cnt   <= '0;
      flash <= 1'b0;
    end else begin
      if (accept) hp <= (hp > hit_dmg) ? hp - hit_dmg : 7'd0;
      cnt   <= cnt_nxt;
      flash <= (cnt_nxt != '0);
    end
  end
endmodule

// File: rtl/boss_ctl.sv
// Boss motion FSM (patrol / dive / return) and writer of the boss sprite position and HP.
module boss_ctl
  import boss_pkg::*;
#(
  parameter int START_X       = 400,
  parameter int Y_HOME        = 150,
  parameter int SPEED         = 3,
  parameter int DIVE_SPEED    = 6,
  parameter int RISE_SPEED    = 2,
  parameter int CHARGE_PERIOD = 180,
  parameter int INVULN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_active,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic [6:0]  hit_dmg,
  output logic [11:0] boss_x,
  output logic [11:0] boss_y,
  output logic [6:0]  boss_hp,
  output logic        boss_dead,
  output logic        boss_flash
);
  localparam int FW = $clog2(CHARGE_PERIOD + 1);

  // Thresholds are pre-offset by the step so no comparison can under/overflow.
  localparam logic [11:0] X0     = 12'(START_X);
  localparam logic [11:0] Y0     = 12'(Y_HOME);
  localparam logic [11:0] XLO    = 12'(X_MIN);
  localparam logic [11:0] XHI    = 12'(X_MAX);
  localparam logic [11:0] YLO    = 12'(Y_LOW);
  localparam logic [11:0] SPD    = 12'(SPEED);
  localparam logic [11:0] DIVE   = 12'(DIVE_SPEED);
  localparam logic [11:0] RISE   = 12'(RISE_SPEED);
  localparam logic [11:0] X_LEFT = 12'(X_MIN + SPEED);
  localparam logic [11:0] X_RGT  = 12'(X_MAX - SPEED);
  localparam logic [11:0] Y_DIVE = 12'(Y_LOW - DIVE_SPEED);
  localparam logic [11:0] Y_RISE = 12'(Y_HOME + RISE_SPEED);
  localparam logic [FW-1:0] F_LAST = FW'(CHARGE_PERIOD - 1);

  boss_state_t   state, state_nxt;
  logic [11:0]   x_nxt, y_nxt;
  logic          dir, dir_nxt;   // 1 = moving right
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          live, hp_zero;

  assign live = (state == PATROL) || (state == CHARGE) || (state == RETURN);

  boss_hp_ctl #(.INVULN_FRAMES(INVULN_FRAMES)) u_hp (
    .clk        (clk),
    .rst        (rst),
    .clr        (!game_active),
    .live       (live),
    .frame_tick (frame_tick),
    .hit        (hit),
    .hit_dmg    (hit_dmg),
    .hp         (boss_hp),
    .flash      (boss_flash),
    .hp_zero    (hp_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = PATROL;
      PATROL:  if (frame_tick && fcnt == F_LAST) state_nxt = CHARGE;
      CHARGE:  if (frame_tick && boss_y >= Y_DIVE) state_nxt = RETURN;
      RETURN:  if (frame_tick && boss_y <= Y_RISE) state_nxt = PATROL;
      default: state_nxt = state;
    endcase
    if (hp_zero)      state_nxt = DEAD;
    if (!game_active) state_nxt = IDLE;
  end

  always_comb begin
    x_nxt    = boss_x;
    y_nxt    = boss_y;
    dir_nxt  = dir;
    fcnt_nxt = fcnt;
    case (state)
      IDLE: begin
        x_nxt = X0; y_nxt = Y0; dir_nxt = 1'b1; fcnt_nxt = '0;
      end
      PATROL: if (frame_tick) begin
        fcnt_nxt = (fcnt == F_LAST) ? '0 : fcnt + 1'b1;
        if (dir) begin
          if (boss_x >= X_RGT) begin x_nxt = XHI; dir_nxt = 1'b0; end
          else                       x_nxt = boss_x + SPD;
        end else begin
          if (boss_x <= X_LEFT) begin x_nxt = XLO; dir_nxt = 1'b1; end
          else                        x_nxt = boss_x - SPD;
        end
      end
      CHARGE: if (frame_tick) y_nxt = (boss_y >= Y_DIVE) ? YLO : boss_y + DIVE;
      RETURN: if (frame_tick) y_nxt = (boss_y <= Y_RISE) ? Y0 : boss_y - RISE;
      default: ;
    endcase
    if (!game_active) begin
      x_nxt = X0; y_nxt = Y0; dir_nxt = 1'b1; fcnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boss_x    <= X0;
      boss_y    <= Y0;
      dir       <= 1'b1;
      fcnt      <= '0;
      boss_dead <= 1'b0;
    end else begin
      boss_x    <= x_nxt;
      boss_y    <= y_nxt;
      dir       <= dir_nxt;
      fcnt      <= fcnt_nxt;
      boss_dead <= (state_nxt == DEAD);
    end
  end
endmodule
